// File: rtl/task_os_pkg.sv
// Shared definitions for the per-node task OS blocks: opcodes, entry/op word
// field positions and the dispatcher state encoding.
`timescale 1ns/1ps
package task_os_pkg;

    localparam logic [3:0] OP_READY    = 4'h1;
    localparam logic [3:0] OP_SUSPEND  = 4'h2;
    localparam logic [3:0] OP_WAIT     = 4'h3;
    localparam logic [3:0] OP_KILL     = 4'h4;
    localparam logic [3:0] OP_PRIO     = 4'h5;
    localparam logic [3:0] OP_HIT      = 4'h6;
    localparam logic [3:0] OP_EXEC     = 4'h7;
    localparam logic [3:0] OP_KILL_ALL = 4'hC;

    // Packed scheduler entry: {priority, id}
    localparam int ENTRY_PRIO_LSB = 4;
    localparam int ENTRY_ID_LSB   = 0;

    // Op word: {4'h0, id, opcode, arg}
    localparam int OP_ID_LSB   = 8;
    localparam int OP_CODE_LSB = 4;
    localparam int OP_ARG_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2,
        SLICE = 2'd3
    } state_t;

    function automatic logic [15:0] make_op(input logic [3:0] id,
                                            input logic [3:0] opcode,
                                            input logic [3:0] arg);
        logic [15:0] op;
        op = 16'h0000;
        op[OP_ID_LSB   +: 4] = id;
        op[OP_CODE_LSB +: 4] = opcode;
        op[OP_ARG_LSB  +: 4] = arg;
        return op;
    endfunction

endpackage

// File: rtl/task_sorter_dispatch_slice_timer.sv
// Loadable down-counter; done is high in the cycle the loaded count reaches 0,
// so a load of N-1 yields a window of N cycles ending with done.
`timescale 1ns/1ps
module slice_timer #(
    parameter int WIDTH = 14
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_reg;
    logic             running_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_reg   <= '0;
            running_reg <= 1'b0;
        end else if (load) begin
            count_reg   <= load_value;
            running_reg <= 1'b1;
        end else if (running_reg) begin
            if (count_reg == '0) begin
                running_reg <= 1'b0;
            end else begin
                count_reg <= count_reg - WIDTH'(1);
            end
        end
    end

    assign done = running_reg && (count_reg == '0);

endmodule

// File: rtl/task_sorter_dispatch.sv
// Node dispatcher: scans task entries one per cycle, issues Execute to the
// highest-priority ready task, then lets it own the node for a fixed slice.
`timescale 1ns/1ps
module task_sorter_dispatch
    import task_os_pkg::*;
#(
    parameter int NUM_TASKS    = 8,
    parameter int SLICE_CYCLES = 10000
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EN,
    input  logic [8*NUM_TASKS-1:0] in_entries,
    output logic [15:0]            out_op,
    output logic                   out_op_valid,
    output logic [3:0]             cur_task_id,
    output logic                   busy,
    output logic                   idle_flag,
    output logic [15:0]            dispatch_count
);

    localparam int IW = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;
    localparam int SW = $clog2(SLICE_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_TASKS - 1);
    localparam logic [SW-1:0] SLICE_LOAD = SW'(SLICE_CYCLES - 1);

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic            best_valid_reg, best_valid_next;
    logic [3:0]      best_prio_reg, best_prio_next;
    logic [3:0]      best_id_reg, best_id_next;
    logic [15:0]     out_op_reg, out_op_next;
    logic            out_op_valid_reg, out_op_valid_next;
    logic [3:0]      cur_task_id_reg, cur_task_id_next;
    logic            busy_reg;
    logic            idle_flag_reg, idle_flag_next;
    logic [15:0]     dispatch_count_reg, dispatch_count_next;

    logic [7:0]      entry;
    logic [3:0]      entry_prio;
    logic [3:0]      entry_id;
    logic            take_entry;
    logic            cand_valid;
    logic [3:0]      cand_prio;
    logic [3:0]      cand_id;
    logic            timer_load;
    logic            timer_done;

    slice_timer #(
        .WIDTH(SW)
    ) u_slice_timer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (timer_load),
        .load_value(SLICE_LOAD),
        .done      (timer_done)
    );

    // Entry under the scan pointer is read live; strict '>' keeps ties on the lower index.
    assign entry      = in_entries[{idx_reg, 3'b000} +: 8];
    assign entry_prio = entry[ENTRY_PRIO_LSB +: 4];
    assign entry_id   = entry[ENTRY_ID_LSB +: 4];
    assign take_entry = (entry_id != 4'h0) && (!best_valid_reg || (entry_prio > best_prio_reg));
    assign cand_valid = take_entry || best_valid_reg;
    assign cand_prio  = take_entry ? entry_prio : best_prio_reg;
    assign cand_id    = take_entry ? entry_id   : best_id_reg;

    always_comb begin
        state_next          = state_reg;
        idx_next            = idx_reg;
        best_valid_next     = best_valid_reg;
        best_prio_next      = best_prio_reg;
        best_id_next        = best_id_reg;
        out_op_next         = 16'h0000;
        out_op_valid_next   = 1'b0;
        cur_task_id_next    = cur_task_id_reg;
        idle_flag_next      = idle_flag_reg;
        dispatch_count_next = dispatch_count_reg;
        timer_load          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (EN) begin
                    state_next      = SCAN;
                    idx_next        = '0;
                    best_valid_next = 1'b0;
                    best_prio_next  = 4'h0;
                    best_id_next    = 4'h0;
                end
            end
            SCAN: begin
                if (!EN) begin
                    state_next = IDLE;
                end else if (idx_reg == LAST_IDX) begin
                    idx_next        = '0;
                    best_valid_next = 1'b0;
                    best_prio_next  = 4'h0;
                    best_id_next    = 4'h0;
                    if (cand_valid) begin
                        // Outputs are registered, so the Execute word is formed here
                        // and appears during the ISSUE cycle.
                        state_next          = ISSUE;
                        idle_flag_next      = 1'b0;
                        out_op_next         = make_op(cand_id, OP_EXEC, 4'h0);
                        out_op_valid_next   = 1'b1;
                        cur_task_id_next    = cand_id;
                        dispatch_count_next = (dispatch_count_reg == 16'hFFFF) ?
                                              dispatch_count_reg : dispatch_count_reg + 16'd1;
                    end else begin
                        idle_flag_next = 1'b1;
                    end
                end else begin
                    idx_next        = idx_reg + IW'(1);
                    best_valid_next = cand_valid;
                    best_prio_next  = cand_prio;
                    best_id_next    = cand_id;
                end
            end
            ISSUE: begin
                state_next = SLICE;
                timer_load = 1'b1;
            end
            SLICE: begin
                if (timer_done) begin
                    if (EN) begin
                        state_next      = SCAN;
                        idx_next        = '0;
                        best_valid_next = 1'b0;
                        best_prio_next  = 4'h0;
                        best_id_next    = 4'h0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg          <= IDLE;
            idx_reg            <= '0;
            best_valid_reg     <= 1'b0;
            best_prio_reg      <= 4'h0;
            best_id_reg        <= 4'h0;
            out_op_reg         <= 16'h0000;
            out_op_valid_reg   <= 1'b0;
            cur_task_id_reg    <= 4'h0;
            busy_reg           <= 1'b0;
            idle_flag_reg      <= 1'b0;
            dispatch_count_reg <= 16'h0000;
        end else begin
            state_reg          <= state_next;
            idx_reg            <= idx_next;
            best_valid_reg     <= best_valid_next;
            best_prio_reg      <= best_prio_next;
            best_id_reg        <= best_id_next;
            out_op_reg         <= out_op_next;
            out_op_valid_reg   <= out_op_valid_next;
            cur_task_id_reg    <= cur_task_id_next;
            busy_reg           <= (state_next != IDLE);
            idle_flag_reg      <= idle_flag_next;
            dispatch_count_reg <= dispatch_count_next;
        end
    end

    assign out_op         = out_op_reg;
    assign out_op_valid   = out_op_valid_reg;
    assign cur_task_id    = cur_task_id_reg;
    assign busy           = busy_reg;
    assign idle_flag      = idle_flag_reg;
    assign dispatch_count = dispatch_count_reg;

endmodule

// File: tb/tb_task_sorter_dispatch.sv
// Self-checking bench for task_sorter_dispatch with NUM_TASKS=4, SLICE_CYCLES=8:
// vector table, hand-written corner sequences, and randomized scans vs. an argmax model.
`timescale 1ns/1ps
module tb_task_sorter_dispatch;

    localparam int N = 4;
    localparam int S = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          EN = 1'b0;
    logic [31:0]   in_entries = 32'h0;
    logic [15:0]   out_op;
    logic          out_op_valid;
    logic [3:0]    cur_task_id;
    logic          busy;
    logic          idle_flag;
    logic [15:0]   dispatch_count;

    int total = 0;
    int bad = 0;

    task_sorter_dispatch #(
        .NUM_TASKS   (N),
        .SLICE_CYCLES(S)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .EN            (EN),
        .in_entries    (in_entries),
        .out_op        (out_op),
        .out_op_valid  (out_op_valid),
        .cur_task_id   (cur_task_id),
        .busy          (busy),
        .idle_flag     (idle_flag),
        .dispatch_count(dispatch_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] entries;
        logic        exp_valid;
        logic [3:0]  exp_id;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        EN  = 1'b0;
        RST = 1'b1;
        #2;
        RST = 1'b0;
    endtask

    // Highest priority valid entry, earliest index on ties; 0 when none is ready.
    function automatic logic [3:0] model_pick(input logic [31:0] e);
        int best_prio;
        logic [3:0] best_id;
        logic [7:0] b;
        best_prio = -1;
        best_id   = 4'h0;
        for (int i = 0; i < N; i++) begin
            b = e[8*i +: 8];
            if (b[3:0] != 4'h0 && int'(b[7:4]) > best_prio) begin
                best_prio = int'(b[7:4]);
                best_id   = b[3:0];
            end
        end
        return best_id;
    endfunction

    function automatic logic [31:0] rand_entries();
        logic [31:0] e;
        e = $urandom;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) e[8*i +: 8] = 8'h00;
        end
        if ($urandom_range(0, 7) == 0) e = 32'h0;
        return e;
    endfunction

    initial begin
        logic [3:0]  pick;
        logic [31:0] ent;
        int          model_count;
        logic        seen_valid;

        vecs[0] = '{32'h00125123, 1'b1, 4'h1};
        vecs[1] = '{32'h00004745, 1'b1, 4'h5};
        vecs[2] = '{32'h00000300, 1'b1, 4'h3};
        vecs[3] = '{32'h00000000, 1'b0, 4'h0};
        vecs[4] = '{32'hF4131211, 1'b1, 4'h4};
        vecs[5] = '{32'hE0A09070, 1'b0, 4'h0};

        // Reset state
        do_reset();
        step();
        chk("reset_op", {15'h0, out_op_valid, out_op}, 32'h0);
        chk("reset_cur", 32'(cur_task_id), 32'h0);
        chk("reset_busy", {30'h0, busy, idle_flag}, 32'h0);
        chk("reset_count", 32'(dispatch_count), 32'h0);

        // Vector table: one scan from IDLE
        for (int v = 0; v < 6; v++) begin
            do_reset();
            in_entries = vecs[v].entries;
            EN = 1'b1;
            seen_valid = 1'b0;
            for (int s = 0; s < N; s++) begin
                step();
                if (out_op_valid || out_op != 16'h0) seen_valid = 1'b1;
            end
            chk($sformatf("vec%0d_quiet_scan", v), 32'(seen_valid), 32'h0);
            step();
            chk($sformatf("vec%0d_valid", v), 32'(out_op_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                chk($sformatf("vec%0d_op", v), 32'(out_op), {16'h0, 4'h0, vecs[v].exp_id, 8'h70});
                chk($sformatf("vec%0d_cur", v), 32'(cur_task_id), 32'(vecs[v].exp_id));
            end else begin
                chk($sformatf("vec%0d_idle", v), 32'(idle_flag), 32'h1);
            end
            step();
            chk($sformatf("vec%0d_op_clear", v), {15'h0, out_op_valid, out_op}, 32'h0);
        end

        // Tie, then entry 1 raised during the slice before its next scan slot
        do_reset();
        in_entries = 32'h00004745;
        EN = 1'b1;
        for (int s = 0; s <= N; s++) step();
        chk("tie_op", 32'(out_op), 32'h0570);
        step();
        in_entries = 32'h00005745;
        seen_valid = 1'b0;
        for (int s = 0; s < S + N - 1; s++) begin
            step();
            if (out_op_valid) seen_valid = 1'b1;
        end
        chk("tie_gap_quiet", 32'(seen_valid), 32'h0);
        step();
        chk("raise_valid", 32'(out_op_valid), 32'h1);
        chk("raise_op", 32'(out_op), 32'h0770);
        chk("raise_cur", 32'(cur_task_id), 32'h7);
        chk("raise_count", 32'(dispatch_count), 32'h2);

        // No ready entries: continuous rescanning
        do_reset();
        in_entries = 32'h0;
        EN = 1'b1;
        for (int s = 0; s < N; s++) step();
        chk("empty_idle_pre", 32'(idle_flag), 32'h0);
        step();
        chk("empty_idle", 32'(idle_flag), 32'h1);
        seen_valid = 1'b0;
        for (int s = 0; s < 3 * N; s++) begin
            step();
            if (out_op_valid) seen_valid = 1'b1;
        end
        chk("empty_no_valid", 32'(seen_valid), 32'h0);
        chk("empty_busy", 32'(busy), 32'h1);

        // EN dropped during the third scan cycle
        do_reset();
        in_entries = 32'h00125123;
        EN = 1'b1;
        step(); step(); step();
        EN = 1'b0;
        step();
        chk("scan_abort_busy", 32'(busy), 32'h0);
        seen_valid = 1'b0;
        for (int s = 0; s < 10; s++) begin
            step();
            if (out_op_valid) seen_valid = 1'b1;
        end
        chk("scan_abort_no_op", 32'(seen_valid), 32'h0);
        chk("scan_abort_count", 32'(dispatch_count), 32'h0);

        // EN dropped during the slice: full slice, then IDLE
        do_reset();
        in_entries = 32'h00125123;
        EN = 1'b1;
        for (int s = 0; s <= N; s++) step();
        chk("slice_drop_issue", 32'(out_op_valid), 32'h1);
        step();
        EN = 1'b0;
        for (int s = 0; s < S - 1; s++) step();
        chk("slice_drop_last_busy", 32'(busy), 32'h1);
        step();
        chk("slice_drop_idle", 32'(busy), 32'h0);
        chk("slice_drop_count", 32'(dispatch_count), 32'h1);

        // Reset asserted inside the ISSUE cycle
        do_reset();
        in_entries = 32'h00125123;
        EN = 1'b1;
        for (int s = 0; s <= N; s++) step();
        chk("rst_issue_pre", 32'(out_op_valid), 32'h1);
        RST = 1'b1;
        #1;
        chk("rst_issue_op", {15'h0, out_op_valid, out_op}, 32'h0);
        chk("rst_issue_count", 32'(dispatch_count), 32'h0);
        chk("rst_issue_busy", 32'(busy), 32'h0);
        #1;
        RST = 1'b0;
        EN = 1'b0;
        step(); step();
        chk("rst_issue_stays_idle", {30'h0, busy, out_op_valid}, 32'h0);

        // Saturation from a preloaded count
        do_reset();
        force dut.dispatch_count_reg = 16'hFFFE;
        #1;
        release dut.dispatch_count_reg;
        in_entries = 32'h00000021;
        EN = 1'b1;
        for (int s = 0; s <= N; s++) step();
        chk("sat_first", 32'(dispatch_count), 32'hFFFF);
        for (int s = 0; s < S + N + 1; s++) step();
        chk("sat_second_valid", 32'(out_op_valid), 32'h1);
        chk("sat_second", 32'(dispatch_count), 32'hFFFF);

        // Randomized scans against the argmax model
        for (int r = 0; r < 20; r++) begin
            do_reset();
            model_count = 0;
            ent = rand_entries();
            pick = model_pick(ent);
            in_entries = ent;
            EN = 1'b1;
            for (int s = 0; s <= N; s++) step();
            chk($sformatf("rnd%0d_valid", r), 32'(out_op_valid), 32'(pick != 4'h0));
            if (pick != 4'h0) begin
                model_count++;
                chk($sformatf("rnd%0d_op", r), 32'(out_op), {20'h0, pick, 8'h70});
                step();
                ent = rand_entries();
                pick = model_pick(ent);
                in_entries = ent;
                for (int s = 0; s < S + N; s++) step();
                chk($sformatf("rnd%0d_valid2", r), 32'(out_op_valid), 32'(pick != 4'h0));
                if (pick != 4'h0) begin
                    model_count++;
                    chk($sformatf("rnd%0d_op2", r), 32'(out_op), {20'h0, pick, 8'h70});
                end
                chk($sformatf("rnd%0d_count", r), 32'(dispatch_count), 32'(model_count));
            end else begin
                chk($sformatf("rnd%0d_idle", r), 32'(idle_flag), 32'h1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/task_sorter_dispatch.md
Name: task_sorter_dispatch

Overview:
Downstream consumer of the per-task FSM sorter outputs for one node. It scans the packed {priority, id} entries of all tasks and selects the highest-priority ready task. It then issues that task's Execute op on the node op bus and holds a fixed time slice before rescanning. Its out_op drives the in_op_nodeX bus of every task module on that node.

Parameters:
NUM_TASKS, 8, number of task entries scanned (legal 1..15)
SLICE_CYCLES, 10000, cycles a dispatched task owns the node before rescan (>=1)

Ports:
CLK  input  1  clock
RST  input  1  reset; asynchronous, active-high
EN  input  1  scheduler enable
in_entries  input  8*NUM_TASKS  entry i = bits [8i+7:8i]; [7:4] priority, [3:0] task id; 8'h00 = not ready
out_op  output  16  op word to task modules: {4'h0, id[3:0], opcode[3:0], arg[3:0]}
out_op_valid  output  1  high in the single cycle out_op carries a command
cur_task_id  output  4  id of the last dispatched task; 0 = none
busy  output  1  high in SCAN, ISSUE and SLICE
idle_flag  output  1  last completed scan found no ready entry
dispatch_count  output  16  number of Execute ops issued, saturating at 16'hFFFF

Behaviour:
- Reset values (async): state IDLE; out_op 16'h0000; out_op_valid 0; cur_task_id 0; busy 0; idle_flag 0; dispatch_count 0; scan index 0; best register cleared; slice counter 0.
- out_op is 16'h0000 (undefined op, ignored by tasks) in every cycle except ISSUE. All outputs are registered.
- Entry is valid iff bits [3:0] != 0. Id 0 is reserved. Priority 0 with a nonzero id is a valid, lowest-priority entry.
- States:
  - IDLE: stays while EN=0. With EN=1 → SCAN, index=0, best cleared.
  - SCAN: one entry per cycle, index 0..NUM_TASKS-1. Entry i is sampled live in its own scan cycle; there is no snapshot.
    - A valid entry replaces best only if its priority is strictly greater than best's, or no best is held yet. Ties go to the lower index.
    - At index NUM_TASKS-1 with a best held → ISSUE, idle_flag=0.
    - At index NUM_TASKS-1 with no best → SCAN again (index=0, best cleared), idle_flag=1.
    - EN=0 in any SCAN cycle → IDLE next cycle. The partial scan is discarded and idle_flag is unchanged.
  - ISSUE (exactly 1 cycle):
    - out_op = {4'h0, best_id, 4'h7, 4'h0}; out_op_valid=1.
    - cur_task_id=best_id; dispatch_count+1, saturating.
    - Next state SLICE with counter = SLICE_CYCLES-1.
  - SLICE: counter decrements each cycle. At 0 → SCAN if EN=1, else IDLE. EN changes inside SLICE do not shorten the slice.
- Latency: first IDLE cycle sampling EN=1 at edge k. SCAN occupies cycles k+1..k+NUM_TASKS. out_op_valid is high in cycle k+NUM_TASKS+1.
- Period with ready tasks present: NUM_TASKS + 1 + SLICE_CYCLES cycles per dispatch.
- Slice counter width is $clog2(SLICE_CYCLES+1). Index width is $clog2(NUM_TASKS) (minimum 1).
- Reset mid-operation aborts immediately. Any in-flight command is dropped, not replayed.

Decomposition:
- Shared package task_os_pkg:
  - opcode constants OP_READY=4'h1, OP_SUSPEND=4'h2, OP_WAIT=4'h3, OP_KILL=4'h4, OP_PRIO=4'h5, OP_HIT=4'h6, OP_EXEC=4'h7, OP_KILL_ALL=4'hC
  - entry field positions: PRIO [7:4], ID [3:0]
  - op word field positions: ID [11:8], OPCODE [7:4], ARG [3:0]
  - state enum IDLE/SCAN/ISSUE/SLICE
- One natural sub-module: slice_timer. It takes a load/value input and produces a down-counter and a done pulse, reusable by the task modules' 10000-cycle refresh.

Test Plan:
- NUM_TASKS=4, SLICE_CYCLES=8, entries {0x23, 0x51, 0x12, 0x00}, EN raised at edge k → out_op=16'h0170 and valid only in cycle k+5; cur_task_id=1; next dispatch at k+18.
- Tie: entries {0x45, 0x47, 0x00, 0x00} → dispatches id 5 (lower index); a raise of entry 1 to 0x57 before its next scan slot → next dispatch id 7.
- All entries 0x00 → idle_flag=1 after 4 scan cycles, out_op_valid never asserted, continuous rescanning, busy=1.
- EN dropped during the 3rd scan cycle → IDLE next cycle, no op issued. EN dropped during SLICE → full 8-cycle slice completes, then IDLE, busy=0.
- RST pulsed in the ISSUE cycle → out_op=0 and valid=0 immediately (async), dispatch_count=0, state IDLE.
- Preload to 16'hFFFE, then two dispatches → count saturates at 16'hFFFF.
